demux_1to2_buf: RTL

DEMUX_1TO2_BUF -- requirements
Module: demux_1to2_buf

---
 rtl/demux_1to2_buf.sv | 130 +++++++++++++
 1 files changed

// File: rtl/demux_1to2_buf.sv
// rtl/demux_1to2_buf.sv - 1-to-2 stream demux with a 2-entry FIFO per output port
// Optional transfer counters compiled in by DEMUX_1TO2_BUF_STATS_EN.
`timescale 1ns/1ps

module demux_1to2_buf_fifo #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  logic [size-1:0] wr_data,
  input  logic            ready,
  output logic            full,
  output logic            valid,
  output logic [size-1:0] head
);

  logic [1:0]      count;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [size-1:0] mem [2];
  logic [size-1:0] hold_q;
  logic            pop;

  assign valid = (count != 2'd0);
  assign full  = (count == 2'd2);
  assign pop   = valid & ready;
  // Re-present the last visible head while empty so the output never jumps to stale slots.
  assign head  = valid ? mem[rd_ptr] : hold_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
      hold_q <= '0;
    end else begin
      hold_q <= head;
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

module demux_1to2_buf #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic            valid_i,
  input  logic            select_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic [size-1:0] data1_o,
  output logic            valid0_o,
  output logic            valid1_o,
  input  logic            ready0_i,
  input  logic            ready1_i,
  output logic [15:0]     cnt0_o,
  output logic [15:0]     cnt1_o
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;

  // No bypass: a full FIFO refuses input even when its downstream is draining.
  assign ready_o = select_i ? ~full1 : ~full0;
  assign push0   = valid_i & ready_o & ~select_i;
  assign push1   = valid_i & ready_o &  select_i;

  demux_1to2_buf_fifo #(.size(size)) u_fifo0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push0),
    .wr_data (data_i),
    .ready   (ready0_i),
    .full    (full0),
    .valid   (valid0_o),
    .head    (data0_o)
  );

  demux_1to2_buf_fifo #(.size(size)) u_fifo1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push1),
    .wr_data (data_i),
    .ready   (ready1_i),
    .full    (full1),
    .valid   (valid1_o),
    .head    (data1_o)
  );

`ifdef DEMUX_1TO2_BUF_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      if (valid0_o & ready0_i) cnt0_q <= cnt0_q + 16'd1;
      if (valid1_o & ready1_i) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign cnt0_o = cnt0_q;
  assign cnt1_o = cnt1_q;
`else
  assign cnt0_o = 16'd0;
  assign cnt1_o = 16'd0;
`endif

endmodule
